poly_row_accumulator: RTL and testbench

POLY_ROW_ACCUMULATOR -- requirements
Module: poly_row_accumulator

---
 rtl/poly_row_accumulator.sv | 169 ++++++++++++++++
 tb/tb_poly_row_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_row_accumulator.sv
// Row-serial 4x4 polynomial multiplier over 8-bit coefficients, driven by sticky sequencer strobes.
// Optional POLY_NEGACYCLIC_EN folds the 7-coefficient product modulo x^4+1.
module poly_row_accumulator (
    input  logic           clk,
    input  logic           reset,
    input  logic           sign0,
    input  logic           sign1,
    input  logic           sign2,
    input  logic           sign3,
    input  logic           halt,
    input  logic [31:0]    a,
    input  logic [31:0]    b,
    output logic [125:0]   result,
    output logic           row_ack,
    output logic [3:0]     rows_done,
    output logic           done,
    output logic           err
);

    localparam int unsigned CW = 8;   // operand coefficient width
    localparam int unsigned NC = 4;   // operand coefficients
    localparam int unsigned PW = 16;  // product width
    localparam int unsigned SW = 18;  // accumulator width
    localparam int unsigned NR = 7;   // result coefficients

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t                  state, next_state;
    logic [NC-1:0]           sign_q;
    logic                    halt_q;
    logic [4:0]              rise;
    logic                    multi;
    logic [1:0]              sign_idx;
    logic                    accept, load, go_err, go_done;
    logic [1:0]              row;
    logic [31:0]             a_lat, b_lat, op_a, op_b;
    logic [CW-1:0]           mult_a;
    logic [NC-1:0][PW-1:0]   prod;
    logic [NR-1:0][SW-1:0]   acc, acc_next;

    // Strobe rising edges; more than one set bit in the same cycle is a protocol error
    assign rise  = {halt, sign3, sign2, sign1, sign0} & ~{halt_q, sign_q};
    assign multi = |(rise & (rise - 5'd1));

    always_comb begin
        sign_idx = 2'd0;
        for (int k = 0; k < int'(NC); k++) begin
            if (rise[k]) sign_idx = 2'(k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        go_err     = 1'b0;
        go_done    = 1'b0;
        row        = 2'd0;
        case (state)
            IDLE: begin
                if (multi) begin
                    next_state = ERR;
                    go_err     = 1'b1;
                end else if (rise[0]) begin
                    next_state = RUN;
                    accept     = 1'b1;
                    load       = 1'b1;
                end else if (rise[4]) begin
                    next_state = DONE;
                    go_done    = 1'b1;
                end else if (|rise[3:1]) begin
                    next_state = ERR;
                    go_err     = 1'b1;
                end
            end
            RUN: begin
                if (multi) begin
                    next_state = ERR;
                    go_err     = 1'b1;
                end else if (rise[4]) begin
                    next_state = DONE;
                    go_done    = 1'b1;
                end else if (|rise[3:0]) begin
                    row = sign_idx;
                    // Row k is only legal directly after row k-1 and only once
                    if (sign_idx != 2'd0 && rows_done[sign_idx - 2'd1] && !rows_done[sign_idx]) begin
                        accept = 1'b1;
                    end else begin
                        next_state = ERR;
                        go_err     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Operands come straight from the ports on the sign0 clock, from the latches afterwards
    assign op_a   = load ? a : a_lat;
    assign op_b   = load ? b : b_lat;
    assign mult_a = op_a[{row, 3'b000} +: CW];

    always_comb begin
        for (int j = 0; j < int'(NC); j++) begin
            prod[j] = PW'(mult_a * op_b[j*CW +: CW]);
        end
    end

    always_comb begin
        acc_next = load ? '0 : acc;
        if (accept) begin
            for (int j = 0; j < int'(NC); j++) begin
                acc_next[3'(row) + 3'(j)] = acc_next[3'(row) + 3'(j)] + SW'(prod[j]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q    <= '0;
            halt_q    <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            acc       <= '0;
            rows_done <= '0;
            row_ack   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            sign_q  <= {sign3, sign2, sign1, sign0};
            halt_q  <= halt;
            acc     <= acc_next;
            row_ack <= accept;
            done    <= done | go_done;
            err     <= err | go_err;
            if (load) begin
                a_lat <= a;
                b_lat <= b;
            end
            if (accept) rows_done <= rows_done | (4'b0001 << row);
        end
    end

`ifdef POLY_NEGACYCLIC_EN
    logic [NR-1:0][SW-1:0] fold_next;

    // x^4 = -1: high coefficients subtract from their low counterparts
    always_comb begin
        fold_next = '0;
        for (int j = 0; j < 3; j++) begin
            fold_next[j] = acc_next[j] - acc_next[j+4];
        end
        fold_next[3] = acc_next[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) result <= '0;
        else       result <= fold_next;
    end
`else
    assign result = acc;
`endif

endmodule

// File: tb/tb_poly_row_accumulator.sv
// Self-checking bench for poly_row_accumulator: directed scenarios plus randomized row sequences
// checked against a plain-arithmetic polynomial product model.
module tb_poly_row_accumulator;

    logic         clk = 1'b0;
    logic         reset;
    logic         sign0, sign1, sign2, sign3, halt;
    logic [31:0]  a, b;
    logic [125:0] result;
    logic         row_ack;
    logic [3:0]   rows_done;
    logic         done, err;

    int checks = 0;
    int errors = 0;

    poly_row_accumulator dut (
        .clk(clk), .reset(reset),
        .sign0(sign0), .sign1(sign1), .sign2(sign2), .sign3(sign3), .halt(halt),
        .a(a), .b(b),
        .result(result), .row_ack(row_ack), .rows_done(rows_done), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [125:0] pack7(input int unsigned c0, c1, c2, c3, c4, c5, c6);
        return {18'(c6), 18'(c5), 18'(c4), 18'(c3), 18'(c2), 18'(c1), 18'(c0)};
    endfunction

    // Product of the first n rows of a with b, optionally folded mod x^4+1, wrapped to 18 bits
    function automatic logic [125:0] model(input logic [31:0] av, input logic [31:0] bv, input int n);
        int unsigned c [7];
        logic [125:0] r;
        for (int p = 0; p < 7; p++) c[p] = 0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++)
                c[k+i] += int'(av[8*k +: 8]) * int'(bv[8*i +: 8]);
`ifdef POLY_NEGACYCLIC_EN
        for (int j = 0; j < 3; j++) c[j] = c[j] - c[j+4];
        for (int j = 4; j < 7; j++) c[j] = 0;
`endif
        r = '0;
        for (int p = 0; p < 7; p++) r[18*p +: 18] = 18'(c[p]);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_strobe(input int k);
        case (k)
            0: sign0 = 1'b1;
            1: sign1 = 1'b1;
            2: sign2 = 1'b1;
            3: sign3 = 1'b1;
            default: halt = 1'b1;
        endcase
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        {sign0, sign1, sign2, sign3, halt} = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        a = $urandom; b = $urandom;
        apply_reset();
        tick();
        checks++;
        if ({result, rows_done, row_ack, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_state got result=%h rows=%b ack=%b done=%b err=%b, want all zero",
                     result, rows_done, row_ack, done, err);
        end
    endtask

    task automatic test_full_product();
        logic [125:0] exp;
        int acks = 0;
`ifdef POLY_NEGACYCLIC_EN
        exp = pack7(32'h3FFC8, 32'h3FFDC, 2, 60, 0, 0, 0);
`else
        exp = pack7(5, 16, 34, 60, 61, 52, 32);
`endif
        apply_reset();
        a = 32'h04030201; b = 32'h08070605;
        for (int k = 0; k < 5; k++) begin
            set_strobe(k);
            tick();
            if (row_ack) acks++;
        end
        tick();
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL full_result got %h want %h", result, exp);
        end
        checks++;
        if ({acks, rows_done, done, err} !== {32'd4, 4'b1111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_flags got acks=%0d rows=%b done=%b err=%b want 4 1111 1 0", acks, rows_done, done, err);
        end
    endtask

    task automatic test_early_halt();
        apply_reset();
        a = 32'h04030201; b = 32'h08070605;
        set_strobe(0); tick();
        set_strobe(1); tick();
        set_strobe(4); tick();
        checks++;
        if ({rows_done, done, err} !== {4'b0011, 1'b1, 1'b0}) begin
            errors++; $display("FAIL early_flags got rows=%b done=%b err=%b want 0011 1 0", rows_done, done, err);
        end
        checks++;
`ifdef POLY_NEGACYCLIC_EN
        if (result !== pack7(32'h3FFF5, 16, 19, 22, 0, 0, 0)) begin
`else
        if (result !== pack7(5, 16, 19, 22, 16, 0, 0)) begin
`endif
            errors++; $display("FAIL early_result got %h", result);
        end
    endtask

    task automatic test_order_violation();
        logic [125:0] exp;
        exp = model(32'h04030201, 32'h08070605, 1);
        apply_reset();
        a = 32'h04030201; b = 32'h08070605;
        set_strobe(0); tick();
        set_strobe(2); tick();
        checks++;
        if ({err, rows_done, result} !== {1'b1, 4'b0001, exp}) begin
            errors++; $display("FAIL order_err got err=%b rows=%b result=%h want 1 0001 %h", err, rows_done, result, exp);
        end
        set_strobe(1); tick();
        set_strobe(3); tick();
        set_strobe(4); tick(); tick();
        checks++;
        if ({err, done, row_ack, rows_done, result} !== {1'b1, 1'b0, 1'b0, 4'b0001, exp}) begin
            errors++;
            $display("FAIL order_frozen got err=%b done=%b ack=%b rows=%b result=%h", err, done, row_ack, rows_done, result);
        end
    endtask

    task automatic test_idle_bad_sign();
        apply_reset();
        set_strobe(3); tick();
        checks++;
        if ({err, rows_done, result} !== {1'b1, 4'b0000, 126'd0}) begin
            errors++; $display("FAIL idle_bad_sign got err=%b rows=%b result=%h want 1 0000 0", err, rows_done, result);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        a = 32'h04030201; b = 32'h08070605;
        sign0 = 1'b1; sign1 = 1'b1;
        tick();
        checks++;
        if ({err, row_ack, rows_done, result} !== {1'b1, 1'b0, 4'b0000, 126'd0}) begin
            errors++; $display("FAIL simultaneous got err=%b ack=%b rows=%b result=%h", err, row_ack, rows_done, result);
        end
    endtask

    task automatic test_halt_idle();
        apply_reset();
        set_strobe(4); tick();
        set_strobe(0); tick();
        checks++;
        if ({done, err, rows_done, result} !== {1'b1, 1'b0, 4'b0000, 126'd0}) begin
            errors++; $display("FAIL halt_idle got done=%b err=%b rows=%b result=%h", done, err, rows_done, result);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        apply_reset();
        a = 32'h04030201; b = 32'h08070605;
        set_strobe(0); tick();
        set_strobe(1); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({result, rows_done, row_ack, done, err} !== '0) begin
            errors++; $display("FAIL reset_mid got result=%h rows=%b ack=%b done=%b err=%b want 0", result, rows_done, row_ack, done, err);
        end
        {sign0, sign1, sign2, sign3, halt} = '0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_strobe(k); tick();
            if (row_ack) acks++;
        end
        checks++;
        if ({acks, result, rows_done, done, err} !== {32'd4, model(32'h04030201, 32'h08070605, 4), 4'b1111, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_rerun got acks=%0d result=%h rows=%b done=%b err=%b", acks, result, rows_done, done, err);
        end
    endtask

    task automatic test_strobe_at_release();
        logic [31:0] av, bv;
        av = $urandom; bv = $urandom;
        reset = 1'b1;
        {sign1, sign2, sign3, halt} = '0;
        sign0 = 1'b1; a = av; b = bv;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({row_ack, rows_done, result} !== {1'b1, 4'b0001, model(av, bv, 1)}) begin
            errors++; $display("FAIL release_edge got ack=%b rows=%b result=%h want 1 0001 %h", row_ack, rows_done, result, model(av, bv, 1));
        end
    endtask

    task automatic test_random_rows();
        for (int it = 0; it < 16; it++) begin
            logic [31:0] av, bv;
            int n;
            av = $urandom; bv = $urandom;
            n  = int'($urandom_range(1, 4));
            apply_reset();
            for (int k = 0; k < n; k++) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    a = $urandom; b = $urandom;
                    tick();
                    checks++;
                    if (row_ack !== 1'b0) begin
                        errors++; $display("FAIL rand_gap_ack it=%0d got %b want 0", it, row_ack);
                    end
                end
                if (k == 0) begin a = av; b = bv; end
                set_strobe(k);
                tick();
                a = $urandom; b = $urandom;
                checks++;
                if ({row_ack, rows_done, result} !== {1'b1, 4'((1 << (k+1)) - 1), model(av, bv, k+1)}) begin
                    errors++;
                    $display("FAIL rand_row it=%0d row=%0d got ack=%b rows=%b result=%h want %h",
                             it, k, row_ack, rows_done, result, model(av, bv, k+1));
                end
            end
            set_strobe(4); tick(); tick();
            checks++;
            if ({done, err, rows_done, result} !== {1'b1, 1'b0, 4'((1 << n) - 1), model(av, bv, n)}) begin
                errors++; $display("FAIL rand_halt it=%0d got done=%b err=%b rows=%b result=%h", it, done, err, rows_done, result);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {sign0, sign1, sign2, sign3, halt} = '0;
        a = '0; b = '0;
        test_reset();
        test_full_product();
        test_early_halt();
        test_order_violation();
        test_idle_bad_sign();
        test_simultaneous();
        test_halt_idle();
        test_reset_mid();
        test_strobe_at_release();
        test_random_rows();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
